// File: rtl/csa_accum_ctl.sv
// rtl/csa_accum_ctl.sv - multi-operand accumulator holding the running sum in carry-save form
// Operands fold into (p, q) with one 3:2 reduction each; the last operand triggers carry resolution.

module csa_accum_ctl_reductor #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] s_o,
  output logic [W-1:0] c_o
);
  logic [W-1:0] maj;

  assign maj = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  assign s_o = a_i ^ b_i ^ c_i;
  // Carry out of the top bit is dropped: all arithmetic is modulo 2^W.
  assign c_o = {maj[W-2:0], 1'b0};
endmodule

module csa_accum_ctl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         busy
);
  typedef enum logic [1:0] {
    ST_ACC     = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] p_q, p_d;
  logic [W-1:0] q_q, q_d;
  logic [W-1:0] sum_q, sum_d;
  logic [W-1:0] red_x, red_s, red_c;

  // Resolve reuses the same reductor with a zero third term.
  assign red_x = (state_q == ST_ACC) ? in_data : '0;

  csa_accum_ctl_reductor #(.W(W)) u_reductor (
    .a_i (p_q),
    .b_i (q_q),
    .c_i (red_x),
    .s_o (red_s),
    .c_o (red_c)
  );

  // Handshake outputs decode registered state only, so no input-to-output path exists.
  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_ACC);
  assign out_sum   = sum_q;

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    sum_d   = sum_q;
    case (state_q)
      ST_ACC: begin
        if (in_valid) begin
          p_d = red_s;
          q_d = red_c;
          if (in_last) state_d = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        if (q_q == '0) begin
          sum_d   = p_q;
          state_d = ST_DONE;
        end else begin
          p_d = red_s;
          q_d = red_c;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          p_d     = '0;
          q_d     = '0;
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      p_q     <= '0;
      q_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      sum_q   <= sum_d;
    end
  end
endmodule
